// File: rtl/branch_resolve_unit.sv
// Multi-cycle RISC-V branch resolver: compares operands CHUNK bits per cycle from the MSB down.
// Optional macro BRANCH_RESOLVE_EARLY_OUT_EN: finish as soon as the first differing chunk is seen.
module branch_resolve_unit #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    input  logic            pred_taken,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic            mispredict
);

    localparam int NCHUNK = XLEN / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [2:0]      r_funct3;
    logic            r_pred;
    logic [CW-1:0]   r_count;
    logic            r_diff_found;
    logic            r_lt_flag;
    logic            r_out_valid;
    logic            r_taken;
    logic            r_mispredict;

    logic [CHUNK-1:0] w_mask;
    logic [CHUNK-1:0] w_a_cmp;
    logic [CHUNK-1:0] w_b_cmp;
    logic             w_flip;
    logic             w_chunk_diff;
    logic             w_chunk_lt;
    logic             w_diff_next;
    logic             w_lt_next;
    logic             w_taken_next;
    logic             w_done_now;

    // Operands shift left each cycle, so the chunk under test is always the top one;
    // the sign bit lives in that chunk only on the first BUSY cycle.
    assign w_flip       = (r_count == {CW{1'b0}}) && !r_funct3[1];
    assign w_mask       = CHUNK'(w_flip) << (CHUNK - 1);
    assign w_a_cmp      = r_a[XLEN-1 -: CHUNK] ^ w_mask;
    assign w_b_cmp      = r_b[XLEN-1 -: CHUNK] ^ w_mask;
    assign w_chunk_diff = (w_a_cmp != w_b_cmp);
    assign w_chunk_lt   = (w_a_cmp < w_b_cmp);
    assign w_diff_next  = r_diff_found | w_chunk_diff;
    assign w_lt_next    = r_diff_found ? r_lt_flag : w_chunk_lt;
    assign w_taken_next = r_funct3[0] ^ (r_funct3[2] ? w_lt_next : !w_diff_next);

`ifdef BRANCH_RESOLVE_EARLY_OUT_EN
    assign w_done_now = (r_count == LAST_CNT) || w_chunk_diff;
`else
    assign w_done_now = (r_count == LAST_CNT);
`endif

    assign in_ready   = !rst && (r_state == ST_IDLE);
    assign out_valid  = r_out_valid;
    assign taken      = r_taken;
    assign mispredict = r_mispredict;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) w_state_next = ST_BUSY;
                else          w_state_next = ST_IDLE;
            end
            ST_BUSY: begin
                if (w_done_now) w_state_next = ST_DONE;
                else            w_state_next = ST_BUSY;
            end
            ST_DONE: begin
                if (out_ready) w_state_next = ST_IDLE;
                else           w_state_next = ST_DONE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Request latch, chunk comparison progress and registered result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a          <= {XLEN{1'b0}};
            r_b          <= {XLEN{1'b0}};
            r_funct3     <= 3'b000;
            r_pred       <= 1'b0;
            r_count      <= {CW{1'b0}};
            r_diff_found <= 1'b0;
            r_lt_flag    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_taken      <= 1'b0;
            r_mispredict <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a          <= a;
                        r_b          <= b;
                        r_funct3     <= funct3;
                        r_pred       <= pred_taken;
                        r_count      <= {CW{1'b0}};
                        r_diff_found <= 1'b0;
                        r_lt_flag    <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    r_a          <= r_a << CHUNK;
                    r_b          <= r_b << CHUNK;
                    r_diff_found <= w_diff_next;
                    r_lt_flag    <= w_lt_next;
                    if (w_done_now) begin
                        r_taken      <= w_taken_next;
                        r_mispredict <= w_taken_next ^ r_pred;
                        r_out_valid  <= 1'b1;
                    end else begin
                        r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    if (out_ready) r_out_valid <= 1'b0;
                end
                default: r_out_valid <= 1'b0;
            endcase
        end
    end

endmodule
